// File: rtl/alu_flags.sv
// alu_flags: 8-bit ALU fused with the Z/C/S/O flags register.
// The result drives a shared internal bus through a tri-state output.
// The registered carry flag feeds back as carry-in for ADC/SBB/RCL/RCR.
// Optional feature macro: ALU_SHIFT_EN enables the shifter/rotator (ops 8-12).
// When it is not defined, ops 8-12 yield R=0 with C=0 and O=0.
module alu_flags (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  input  logic       invert,
  input  logic       oe,
  input  logic       flags_we,
  output logic [7:0] result,
  output logic [3:0] flags_next,
  output logic [3:0] flags
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADC   = 4'd1,
    OP_SUB   = 4'd2,
    OP_SBB   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_PASSA = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_SAR   = 4'd10,
    OP_RCL   = 4'd11,
    OP_RCR   = 4'd12,
    OP_INC   = 4'd13,
    OP_DEC   = 4'd14,
    OP_PASSB = 4'd15
  } alu_op_e;

  alu_op_e    op_e;
  logic       cin;
  logic       arith;
  logic [7:0] opb;
  logic [8:0] sum9;
  logic [7:0] r;
  logic [7:0] f;
  logic       c_flag;
  logic       o_flag;

  assign op_e = alu_op_e'(op);
  assign cin  = flags[1];

  // Adder operand selection: opb is the addend actually fed to the adder,
  // so the overflow term below reflects the add as performed.
  always_comb begin
    arith = 1'b0;
    opb   = '0;
    sum9  = '0;
    unique case (op_e)
      OP_ADD: begin arith = 1'b1; opb = b;     sum9 = {1'b0, a} + {1'b0, opb}; end
      OP_ADC: begin arith = 1'b1; opb = b;     sum9 = {1'b0, a} + {1'b0, opb} + {8'd0, cin}; end
      OP_SUB: begin arith = 1'b1; opb = ~b;    sum9 = {1'b0, a} + {1'b0, opb} + 9'd1; end
      OP_SBB: begin arith = 1'b1; opb = ~b;    sum9 = {1'b0, a} + {1'b0, opb} + {8'd0, cin}; end
      OP_INC: begin arith = 1'b1; opb = 8'h01; sum9 = {1'b0, a} + {1'b0, opb}; end
      OP_DEC: begin arith = 1'b1; opb = 8'hFF; sum9 = {1'b0, a} + {1'b0, opb}; end
      default: ;
    endcase
  end

  // Core result and the C/O flags for every opcode.
  always_comb begin
    r      = '0;
    c_flag = 1'b0;
    o_flag = 1'b0;
    if (arith) begin
      r      = sum9[7:0];
      c_flag = sum9[8];
      o_flag = (a[7] == opb[7]) && (r[7] != a[7]);
    end else begin
      unique case (op_e)
        OP_AND:   r = a & b;
        OP_OR:    r = a | b;
        OP_XOR:   r = a ^ b;
        OP_PASSA: r = a;
        OP_PASSB: r = b;
`ifdef ALU_SHIFT_EN
        OP_SHL:   begin r = {a[6:0], 1'b0}; c_flag = a[7]; end
        OP_SHR:   begin r = {1'b0, a[7:1]}; c_flag = a[0]; end
        OP_SAR:   begin r = {a[7], a[7:1]}; c_flag = a[0]; end
        OP_RCL:   begin r = {a[6:0], cin};  c_flag = a[7]; end
        OP_RCR:   begin r = {cin, a[7:1]};  c_flag = a[0]; end
`else
        OP_SHL, OP_SHR, OP_SAR, OP_RCL, OP_RCR: r = '0;
`endif
        default: ;
      endcase
    end
  end

  // Z and S follow the (possibly inverted) output; C and O do not.
  assign f          = invert ? ~r : r;
  assign flags_next = {o_flag, f[7], c_flag, (f == 8'h00)};
  assign result     = oe ? 'z : f;

  // Flags register: reset wins over the active-low write enable.
  always_ff @(posedge clk) begin
    if (rst)
      flags <= '0;
    else if (!flags_we)
      flags <= flags_next;
  end

endmodule

// File: tb/tb_alu_flags.sv
// Scoreboard bench for alu_flags: a driver applies directed vectors and
// pushes expected values; a monitor pops and compares on the falling edge.
module tb_alu_flags;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       invert;
  logic       oe;
  logic       flags_we;
  wire  [7:0] result;
  logic [3:0] flags_next;
  logic [3:0] flags;

  alu_flags dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .op         (op),
    .invert     (invert),
    .oe         (oe),
    .flags_we   (flags_we),
    .result     (result),
    .flags_next (flags_next),
    .flags      (flags)
  );

  // kind: 0 = result equals, 1 = result must not carry F (bus released),
  //       2 = flags_next equals, 3 = registered flags equals
  typedef struct {
    string      name;
    int         kind;
    logic [7:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  bit   done   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input string name, input int kind, input logic [7:0] exp);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic we, input logic [3:0] o,
                       input logic [7:0] va, input logic [7:0] vb,
                       input logic inv, input logic en_n);
    @(posedge clk);
    #1;
    rst = r; flags_we = we; op = o; a = va; b = vb; invert = inv; oe = en_n;
  endtask

  // Monitor: compares every queued expectation against the settled outputs.
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        case (e.kind)
          0: act = result;
          1: act = result;
          2: act = {4'h0, flags_next};
          default: act = {4'h0, flags};
        endcase
        if (e.kind == 1) begin
          if (act !== e.exp) passed++;
          else $display("FAIL %s: result=%h while oe=1, must not be %h", e.name, act, e.exp);
        end else begin
          if (act === e.exp) passed++;
          else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
    end
  end

  initial begin
    rst = 1'b1; flags_we = 1'b0; op = 4'd2; a = 8'h05; b = 8'h05; invert = 1'b0; oe = 1'b0;

    // Reset edge with a SUB pending: flags must still clear.
    drive(1, 0, 4'd2, 8'h05, 8'h05, 0, 0);

    // ADD signed overflow.
    drive(0, 0, 4'd0, 8'h7F, 8'h01, 0, 0);
    expect_val("reset_flags", 3, 8'h00);
    expect_val("add_ovf_res", 0, 8'h80);
    expect_val("add_ovf_fn",  2, 8'h0C);

    // SUB equal: zero, no borrow.
    drive(0, 0, 4'd2, 8'h05, 8'h05, 0, 0);
    expect_val("add_ovf_flags", 3, 8'h0C);
    expect_val("sub_eq_res",    0, 8'h00);
    expect_val("sub_eq_fn",     2, 8'h03);

    // ADC uses registered carry.
    drive(0, 0, 4'd1, 8'h10, 8'h20, 0, 0);
    expect_val("sub_eq_flags", 3, 8'h03);
    expect_val("adc_res",      0, 8'h31);
    expect_val("adc_fn",       2, 8'h00);

    // AND with invert.
    drive(0, 0, 4'd4, 8'hF0, 8'h3C, 1, 0);
    expect_val("adc_flags",   3, 8'h00);
    expect_val("and_inv_res", 0, 8'hCF);
    expect_val("and_inv_fn",  2, 8'h04);

    // Output disabled: bus released, flags_next unchanged.
    drive(0, 0, 4'd4, 8'hF0, 8'h3C, 1, 1);
    expect_val("oe_off_res", 1, 8'hCF);
    expect_val("oe_off_fn",  2, 8'h04);

    // SHL 0x81, plain and inverted.
    drive(0, 0, 4'd8, 8'h81, 8'h00, 0, 0);
`ifdef ALU_SHIFT_EN
    expect_val("shl_res", 0, 8'h02);
    expect_val("shl_fn",  2, 8'h02);
`else
    expect_val("shl_res", 0, 8'h00);
    expect_val("shl_fn",  2, 8'h01);
`endif
    drive(0, 0, 4'd8, 8'h81, 8'h00, 1, 0);
`ifdef ALU_SHIFT_EN
    expect_val("shl_inv_res", 0, 8'hFD);
    expect_val("shl_inv_fn",  2, 8'h06);
`else
    expect_val("shl_inv_res", 0, 8'hFF);
    expect_val("shl_inv_fn",  2, 8'h04);
`endif

    // Establish flags=0011 before the hold window.
    drive(0, 0, 4'd2, 8'h05, 8'h05, 0, 0);
`ifdef ALU_SHIFT_EN
    expect_val("shl_inv_flags", 3, 8'h06);
`else
    expect_val("shl_inv_flags", 3, 8'h04);
`endif

    // Hold: three edges with flags_we=1 while ops change.
    drive(0, 1, 4'd0, 8'h7F, 8'h01, 0, 0);
    expect_val("hold0_flags", 3, 8'h03);
    expect_val("hold_add_fn", 2, 8'h0C);
    drive(0, 1, 4'd14, 8'h00, 8'h55, 0, 0);
    expect_val("hold1_flags", 3, 8'h03);
    expect_val("dec_res",     0, 8'hFF);
    expect_val("dec_fn",      2, 8'h04);
    drive(0, 1, 4'd6, 8'hAA, 8'hAA, 0, 0);
    expect_val("hold2_flags", 3, 8'h03);
    expect_val("xor_fn",      2, 8'h01);

    // RCL and ADC with cin=1 held in the flags.
    drive(0, 1, 4'd11, 8'h80, 8'h00, 0, 0);
    expect_val("hold3_flags", 3, 8'h03);
`ifdef ALU_SHIFT_EN
    expect_val("rcl_res", 0, 8'h01);
    expect_val("rcl_fn",  2, 8'h02);
`else
    expect_val("rcl_res", 0, 8'h00);
    expect_val("rcl_fn",  2, 8'h01);
`endif
    drive(0, 1, 4'd1, 8'hFF, 8'h00, 0, 0);
    expect_val("adc_wrap_res", 0, 8'h00);
    expect_val("adc_wrap_fn",  2, 8'h03);

    // Mid-sequence reset clears flags even with writes disabled.
    drive(1, 1, 4'd0, 8'h7F, 8'h01, 0, 0);

    // SBB with cin=0 borrows.
    drive(0, 0, 4'd3, 8'h05, 8'h05, 0, 0);
    expect_val("midrst_flags", 3, 8'h00);
    expect_val("sbb_res",      0, 8'hFF);
    expect_val("sbb_fn",       2, 8'h04);

    // INC overflow, SUB overflow, PASSB zero.
    drive(0, 0, 4'd13, 8'h7F, 8'h00, 0, 0);
    expect_val("inc_res", 0, 8'h80);
    expect_val("inc_fn",  2, 8'h0C);
    drive(0, 0, 4'd2, 8'h80, 8'h01, 0, 0);
    expect_val("sub_ovf_res", 0, 8'h7F);
    expect_val("sub_ovf_fn",  2, 8'h0A);
    drive(0, 0, 4'd15, 8'h12, 8'h00, 0, 0);
    expect_val("passb_res", 0, 8'h00);
    expect_val("passb_fn",  2, 8'h01);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: %0d expectations left, required 0", q.size());

    done = 1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_flags.md
# alu_flags

Datapath arithmetic/logic unit fused with its 4-bit flags register. It sits between the A/B operand buses and the internal data bus, with the control unit supplying the opcode and enables. The carry flag feeds back as carry-in for ADC/SBB/RCL/RCR. Result drive is tri-state so other sources can share the internal bus.

## Interface
No parameters.
- clk  input  1  rising-edge clock for the flags register.
- rst  input  1  reset; synchronous, active-high.
- a  input  8  first operand.
- b  input  8  second operand.
- op  input  4  operation select (see Operation).
- invert  input  1  1 = bitwise-invert the final result.
- oe  input  1  active-low result output enable.
- flags_we  input  1  active-low flags-register write enable.
- result  output  8  ALU result when oe=0; high-Z when oe=1.
- flags_next  output  4  combinational flags of the current operation.
- flags  output  4  registered flags: [0]=Z, [1]=C, [2]=S, [3]=O.

## Operation
- Core result R (8 bit) by op, cin = flags[1]:
  - 0 ADD a+b
  - 1 ADC a+b+cin
  - 2 SUB a+~b+1
  - 3 SBB a+~b+cin
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 PASSA a
  - 8 SHL, C=a[7]
  - 9 SHR logical, C=a[0]
  - 10 SAR, C=a[0]
  - 11 RCL {a[6:0],cin}, C=a[7]
  - 12 RCR {cin,a[7:1]}, C=a[0]
  - 13 INC a+1
  - 14 DEC a+8'hFF
  - 15 PASSB b
- Arithmetic ops 0–3, 13, 14 use a 9-bit sum; C = bit 8.
  - Subtract C=1 means no borrow.
  - O = signed overflow of the 8-bit add as performed, i.e. (opA[7]==opB'[7]) && (R[7]!=opA[7]), where opB' is the actual second addend.
- Logic/pass ops: C=0, O=0.
- Shift ops: C as listed; O=0.
- Final output F = invert ? ~R : R.
- Z = (F==0) and S = F[7] are both taken from F. C and O are unaffected by invert.
- flags_next = {O,S,C,Z}, computed combinationally regardless of oe.
- result = F when oe=0, else 8'hZZ.

## Timing
- result and flags_next are purely combinational: zero-cycle latency from a/b/op/invert/oe/flags.
- flags register, at rising edge of clk:
  - rst=1: flags <= 4'b0000. Reset has priority over flags_we.
  - else if flags_we=0: flags <= flags_next.
  - else: hold.
- flags reset value is 0000. result has no reset value: it follows its inputs, so with flags=0 and op=ADD, a=b=0, oe=0 gives 0x00.
- Carry-in is always the registered flags[1]. A flags write at edge N affects ADC/SBB/RCL/RCR combinational results only after edge N; there is no combinational loop.
- Reset asserted mid-sequence clears flags at the next edge. The result path is not reset.

## Configuration
- ALU_SHIFT_EN
  - Defined: ops 8–12 behave as above.
  - Undefined: ops 8–12 produce R=8'h00 with C=0 and O=0; Z and S are computed from F as usual (e.g. invert=1 gives F=0xFF, S=1). This saves the shifter/rotator logic.
  - All other ops are identical in both builds.

## Test plan
- Reset: rst=1, flags_we=0, op=SUB, a=b=0x05 for one edge -> flags=0000.
- ADD overflow: rst=0, op=0, a=0x7F, b=0x01, oe=0, flags_we=0 -> result=0x80, flags_next=1100; after the edge, flags=1100.
- SUB equal then ADC chain:
  - op=2, a=b=0x05 -> result=0x00, flags=0011 after the edge.
  - Then op=1, a=0x10, b=0x20 -> result=0x31 (carry-in used), flags_next=0000.
- Invert and tri-state:
  - op=4, a=0xF0, b=0x3C, invert=1 -> result=0xCF, flags_next=0100.
  - Then oe=1 -> result=ZZ, flags_next unchanged.
- Shift (ALU_SHIFT_EN defined): op=8, a=0x81 -> result=0x02, flags_next=0010.
  - Without the macro: same stimulus -> result=0x00, flags_next=0001.
- Hold: flags_we=1 while op/operands change for 3 edges -> flags keeps its prior value. DEC a=0x00 -> result=0xFF, flags_next=0100 (C=0, borrow).
